uart_rx_buffer: RTL and testbench

//  Receive-side stage directly downstream of the UART RX deframer. Takes each completed byte
//  and its received parity bit. Checks the parity and stores byte plus error flag in a FIFO.

---
 rtl/uart_rx_buffer_pkg.sv | 17 +
 rtl/uart_rx_buffer_if.sv | 28 ++
 rtl/uart_rx_buffer_fifo_mem.sv | 28 ++
 rtl/uart_rx_buffer.sv | 94 +++++++++
 tb/tb_uart_rx_buffer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared types and helpers for the UART receive buffer.
package uart_pkg;

    // Widest byte the parity helper handles; narrower bytes are zero-extended.
    localparam int DATA_W = 8;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_t;

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input parity_t mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Deframer-side write strobe, consumer-side read port and status of the RX buffer.
interface uart_rx_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_parity;
    logic                     rx_valid;
    logic                     rd_en;
    logic                     clr_err;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_perr;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic                     overrun;
    logic                     perr_sticky;

    modport master (
        output rx_data, rx_parity, rx_valid, rd_en, clr_err,
        input  rd_data, rd_perr, empty, full, level, overrun, perr_sticky
    );

    modport slave (
        input  rx_data, rx_parity, rx_valid, rd_en, clr_err,
        output rd_data, rd_perr, empty, full, level, overrun, perr_sticky
    );
endinterface

// File: rtl/uart_rx_buffer_fifo_mem.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module uart_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming entry on the write strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Show-ahead read of the addressed entry.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART RX buffer: parity check, FIFO pointers, show-ahead head and sticky error status.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_buffer_if.slave    bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PKG_W = uart_pkg::DATA_W;
    localparam parity_t PAR_MODE = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overrun_q, overrun_d;
    logic              perr_q, perr_d;
    logic              empty, full;
    logic              do_wr, do_rd, drop;
    logic              perr;
    logic [PKG_W-1:0]  par_data;
    logic [DATA_W:0]   mem_rdata;

    // Zero-extension leaves the XOR reduction unchanged, so DATA_W may be narrower than the package width.
    assign par_data = PKG_W'(bus.rx_data);
    assign perr     = bus.rx_parity != calc_parity(par_data, PAR_MODE);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on the same edge frees the slot, so a full FIFO still accepts the frame.
    assign do_wr = bus.rx_valid && (!full || bus.rd_en);
    assign do_rd = bus.rd_en && !empty;
    assign drop  = bus.rx_valid && full && !bus.rd_en;

    // Next-state for pointers and sticky flags; a set event beats a clear in the same cycle.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (bus.clr_err) begin
            overrun_d = 1'b0;
            perr_d    = 1'b0;
        end
        if (drop)          overrun_d = 1'b1;
        if (do_wr && perr) perr_d    = 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_wr),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({perr, bus.rx_data}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Head entry is masked while empty so stale storage never reaches the consumer.
    always_comb begin
        bus.rd_data     = empty ? '0 : mem_rdata[DATA_W-1:0];
        bus.rd_perr     = empty ? 1'b0 : mem_rdata[DATA_W];
        bus.empty       = empty;
        bus.full        = full;
        bus.level       = wr_ptr_q - rd_ptr_q;
        bus.overrun     = overrun_q;
        bus.perr_sticky = perr_q;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    uart_rx_buffer_if #(.DATA_W(8), .DEPTH(8)) bus ();

    uart_rx_buffer #(.DATA_W(8), .DEPTH(8), .ODD_PARITY(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_parity = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clr_err   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = d;
        bus.rx_parity = p;
        step();
        bus.rx_valid  = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #12;
        checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", bus.empty); else passes++;
        checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else passes++;
        checks++; if (bus.level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", bus.level); else passes++;
        checks++; if (bus.overrun !== 1'b0 || bus.perr_sticky !== 1'b0)
            $display("FAIL reset_sticky: got ovr=%b perr=%b expected 0 0", bus.overrun, bus.perr_sticky); else passes++;
        checks++; if (bus.rd_data !== 8'h00 || bus.rd_perr !== 1'b0)
            $display("FAIL reset_head: got %h/%b expected 00/0", bus.rd_data, bus.rd_perr); else passes++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        push(8'h55, 1'b0);
        checks++; if (bus.empty !== 1'b0) $display("FAIL single_empty: got %b expected 0", bus.empty); else passes++;
        checks++; if (bus.level !== 4'd1) $display("FAIL single_level: got %0d expected 1", bus.level); else passes++;
        checks++; if (bus.rd_data !== 8'h55 || bus.rd_perr !== 1'b0)
            $display("FAIL single_head: got %h/%b expected 55/0", bus.rd_data, bus.rd_perr); else passes++;
        pop();
        checks++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00)
            $display("FAIL single_drain: got empty=%b data=%h expected 1 00", bus.empty, bus.rd_data); else passes++;
        // Underflow: pop on empty must not move pointers.
        pop();
        checks++; if (bus.level !== 4'd0 || bus.empty !== 1'b1)
            $display("FAIL underflow: got level=%0d empty=%b expected 0 1", bus.level, bus.empty); else passes++;
    endtask

    task automatic test_parity();
        push(8'h01, 1'b0);
        checks++; if (bus.rd_perr !== 1'b1 || bus.perr_sticky !== 1'b1)
            $display("FAIL parity_bad: got perr=%b sticky=%b expected 1 1", bus.rd_perr, bus.perr_sticky); else passes++;
        pop();
        clear_err();
        checks++; if (bus.perr_sticky !== 1'b0) $display("FAIL parity_clear: got %b expected 0", bus.perr_sticky); else passes++;
        push(8'h01, 1'b1);
        checks++; if (bus.rd_perr !== 1'b0 || bus.perr_sticky !== 1'b0)
            $display("FAIL parity_good: got perr=%b sticky=%b expected 0 0", bus.rd_perr, bus.perr_sticky); else passes++;
        pop();
        // Bad frame and clear on the same edge: the set wins.
        bus.clr_err = 1'b1;
        push(8'h07, 1'b0);
        bus.clr_err = 1'b0;
        checks++; if (bus.perr_sticky !== 1'b1) $display("FAIL parity_set_wins: got %b expected 1", bus.perr_sticky); else passes++;
        pop();
        clear_err();
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 8'(i);
            push(d, ^d);
        end
        checks++; if (bus.full !== 1'b1 || bus.level !== 4'd8)
            $display("FAIL ovr_fill: got full=%b level=%0d expected 1 8", bus.full, bus.level); else passes++;
        push(8'hAA, 1'b1);
        checks++; if (bus.overrun !== 1'b1 || bus.level !== 4'd8)
            $display("FAIL ovr_drop: got ovr=%b level=%0d expected 1 8", bus.overrun, bus.level); else passes++;
        checks++; if (bus.perr_sticky !== 1'b0) $display("FAIL ovr_no_perr: got %b expected 0", bus.perr_sticky); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.rd_data !== 8'(i)) $display("FAIL ovr_order: got %h expected %h", bus.rd_data, 8'(i)); else passes++;
            pop();
        end
        checks++; if (bus.empty !== 1'b1) $display("FAIL ovr_empty: got %b expected 1", bus.empty); else passes++;
        clear_err();
        checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", bus.overrun); else passes++;
    endtask

    task automatic test_full_rw();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 8'h10 + 8'(i);
            push(d, ^d);
        end
        bus.rd_en = 1'b1;
        push(8'hC3, 1'b0);
        bus.rd_en = 1'b0;
        checks++; if (bus.level !== 4'd8 || bus.overrun !== 1'b0)
            $display("FAIL fullrw_level: got level=%0d ovr=%b expected 8 0", bus.level, bus.overrun); else passes++;
        for (int i = 1; i < 9; i++) begin
            d = (i == 8) ? 8'hC3 : 8'h10 + 8'(i);
            checks++; if (bus.rd_data !== d) $display("FAIL fullrw_order: got %h expected %h", bus.rd_data, d); else passes++;
            pop();
        end
        checks++; if (bus.empty !== 1'b1) $display("FAIL fullrw_empty: got %b expected 1", bus.empty); else passes++;
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic [7:0] d;
        logic       p, vld, rd, accept, pop_ok;
        int         sent = 0;
        int         cyc  = 0;
        while ((sent < 40 || q.size() > 0) && cyc < 500) begin
            vld = (sent < 40) && ($urandom_range(0, 3) != 0);
            rd  = (sent >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            p   = 1'($urandom_range(0, 1));
            bus.rx_valid  = vld;
            bus.rx_data   = d;
            bus.rx_parity = p;
            bus.rd_en     = rd;
            if (q.size() > 0) begin
                checks++; if ({bus.rd_perr, bus.rd_data} !== q[0])
                    $display("FAIL rand_head: got %h expected %h", {bus.rd_perr, bus.rd_data}, q[0]); else passes++;
            end
            accept = vld && (q.size() < 8 || rd);
            pop_ok = rd && (q.size() > 0);
            step();
            if (pop_ok) void'(q.pop_front());
            if (accept) q.push_back({p != ^d, d});
            if (vld) sent++;
            checks++; if (bus.level !== 4'(q.size()))
                $display("FAIL rand_level: got %0d expected %0d", bus.level, q.size()); else passes++;
            checks++; if (bus.full === 1'b1 && bus.empty === 1'b1)
                $display("FAIL rand_full_empty: got full=1 empty=1 expected not both"); else passes++;
            cyc++;
        end
        idle_inputs();
        checks++; if (cyc >= 500) $display("FAIL rand_timeout: got %0d cycles expected < 500", cyc); else passes++;
        clear_err();
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        push(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = 8'h20 + 8'(i);
            push(d, ^d);
        end
        checks++; if (bus.level !== 4'd5 || bus.perr_sticky !== 1'b1)
            $display("FAIL mid_pre: got level=%0d perr=%b expected 5 1", bus.level, bus.perr_sticky); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.level !== 4'd0)
            $display("FAIL mid_reset_ptrs: got empty=%b level=%0d expected 1 0", bus.empty, bus.level); else passes++;
        checks++; if (bus.overrun !== 1'b0 || bus.perr_sticky !== 1'b0 || bus.rd_data !== 8'h00)
            $display("FAIL mid_reset_flags: got ovr=%b perr=%b data=%h expected 0 0 00",
                     bus.overrun, bus.perr_sticky, bus.rd_data); else passes++;
        #2 reset = 1'b1;
        step();
        push(8'h3C, 1'b0);
        checks++; if (bus.rd_data !== 8'h3C || bus.level !== 4'd1 || bus.rd_perr !== 1'b0)
            $display("FAIL mid_after: got data=%h level=%0d perr=%b expected 3c 1 0",
                     bus.rd_data, bus.level, bus.rd_perr); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_overrun();
        test_full_rw();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
